// File: rtl/split_load_store_unit.sv
// Split load/store unit: turns one core access into one or two aligned bus
// beats, positions store lanes, reassembles and extends load data, and
// reports bus errors, illegal sizes and unsplit misaligned accesses.
module split_load_store_unit #(
    parameter int XLEN     = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_sign,
    input  logic [1:0]        req_len,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic              mem_err,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              busy
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [XLEN-1:0] BEAT_BYTES = {{(XLEN-8){1'b0}}, 8'(NB)};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, wdata_q, lo_q, hi_q;
    logic [1:0]      len_q;
    logic            sign_q, we_q, err_q, mis_q;

    // Request decode: size code to byte count, natural-alignment test.
    logic [3:0] req_size;
    logic [2:0] req_lowmask;
    logic       req_mis, req_illegal;
    assign req_size    = 4'd1 << req_len;
    assign req_lowmask = req_size[2:0] - 3'd1;
    assign req_mis     = (req_addr[2:0] & req_lowmask) != 3'd0;
    assign req_illegal = (req_len == 2'd3) && (XLEN == 32);

    // Registered access geometry.
    logic [3:0]      size_q;
    logic [OFFW-1:0] off_q;
    logic            crossing, beat_done, in_beat;
    assign size_q    = 4'd1 << len_q;
    assign off_q     = addr_q[OFFW-1:0];
    assign crossing  = (5'(off_q) + 5'(size_q)) > 5'(NB);
    assign in_beat   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    assign beat_done = mem_req && mem_rvalid;

    // Zero- or sign-extend the low size bytes of d.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                               input logic [1:0] len,
                                               input logic sgn);
        logic [XLEN-1:0] r;
        int sh;
        sh = XLEN - (8 << len);
        if (sh < 0) sh = 0;
        r = d << sh;
        if (sgn) r = $signed(r) >>> sh;
        else     r = r >> sh;
        return r;
    endfunction

    // Next-state logic of the access sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid)
                         state_d = (req_illegal || (req_mis && !SPLIT_EN)) ? S_DONE : S_BEAT0;
            S_BEAT0: if (beat_done)
                         state_d = (crossing && !mem_err && SPLIT_EN) ? S_BEAT1 : S_DONE;
            S_BEAT1: if (beat_done) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured request and collected beat data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                len_q   <= req_len;
                sign_q  <= req_sign;
                we_q    <= req_we;
                lo_q    <= '0;
                hi_q    <= '0;
                err_q   <= req_illegal;
                mis_q   <= !req_illegal && req_mis && !SPLIT_EN;
            end
            if (beat_done) begin
                if (state_q == S_BEAT0) lo_q <= mem_rdata;
                else                    hi_q <= mem_rdata;
                err_q <= mem_err;
            end
        end
    end

    // Lane placement across a two-beat window; the upper half feeds beat 1.
    logic [2*NB-1:0]   mask_ones, mask_wide;
    logic [2*XLEN-1:0] wdata_wide;
    logic [XLEN-1:0]   base_addr, rd_low;
    always_comb begin
        mask_ones = '0;
        for (int i = 0; i < 2*NB; i++)
            if (i < int'(size_q)) mask_ones[i] = 1'b1;
        mask_wide  = mask_ones << off_q;
        wdata_wide = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
        rd_low     = XLEN'({hi_q, lo_q} >> {off_q, 3'b000});
        base_addr  = addr_q;
        base_addr[OFFW-1:0] = '0;
    end

    // Bus and response outputs; everything reads zero outside its window.
    always_comb begin
        req_ready      = (state_q == S_IDLE);
        busy           = (state_q != S_IDLE);
        mem_req        = in_beat;
        mem_we         = in_beat && we_q;
        mem_addr       = '0;
        mem_wmask      = '0;
        mem_wdata      = '0;
        if (state_q == S_BEAT0) begin
            mem_addr  = base_addr;
            mem_wmask = mask_wide[NB-1:0];
            mem_wdata = wdata_wide[XLEN-1:0];
        end else if (state_q == S_BEAT1) begin
            mem_addr  = base_addr + BEAT_BYTES;
            mem_wmask = mask_wide[2*NB-1:NB];
            mem_wdata = wdata_wide[2*XLEN-1:XLEN];
        end
        rsp_valid      = (state_q == S_DONE);
        rsp_err        = rsp_valid && err_q;
        rsp_misaligned = rsp_valid && mis_q;
        rsp_rdata      = (rsp_valid && !we_q && !err_q && !mis_q) ?
                         extend(rd_low, len_q, sign_q) : '0;
    end

endmodule

// File: tb/tb_split_load_store_unit.sv
// Bench for split_load_store_unit (XLEN=32): one splitting and one
// non-splitting instance behind a shared memory model, with a scoreboard
// of expected beats and responses.
module tb_split_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, use_ns;
    logic        s_req_valid, n_req_valid;
    logic        req_we, req_sign;
    logic [1:0]  req_len;
    logic [31:0] req_addr, req_wdata;
    logic        mem_rvalid, mem_err;
    logic [31:0] mem_rdata;

    logic        s_req_ready, s_rsp_valid, s_rsp_err, s_rsp_mis, s_mem_req, s_mem_we, s_busy;
    logic [31:0] s_rsp_rdata, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_wmask;
    logic        n_req_ready, n_rsp_valid, n_rsp_err, n_rsp_mis, n_mem_req, n_mem_we, n_busy;
    logic [31:0] n_rsp_rdata, n_mem_addr, n_mem_wdata;
    logic [3:0]  n_mem_wmask;

    split_load_store_unit #(.XLEN(32), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_we(req_we), .req_sign(req_sign), .req_len(req_len), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata),
        .rsp_err(s_rsp_err), .rsp_misaligned(s_rsp_mis), .mem_req(s_mem_req),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_wmask(s_mem_wmask), .mem_rvalid(mem_rvalid), .mem_err(mem_err),
        .mem_rdata(mem_rdata), .busy(s_busy));

    split_load_store_unit #(.XLEN(32), .SPLIT_EN(1'b0)) dut_ns (
        .clk(clk), .reset_n(reset_n), .req_valid(n_req_valid), .req_ready(n_req_ready),
        .req_we(req_we), .req_sign(req_sign), .req_len(req_len), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(n_rsp_valid), .rsp_rdata(n_rsp_rdata),
        .rsp_err(n_rsp_err), .rsp_misaligned(n_rsp_mis), .mem_req(n_mem_req),
        .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
        .mem_wmask(n_mem_wmask), .mem_rvalid(mem_rvalid), .mem_err(mem_err),
        .mem_rdata(mem_rdata), .busy(n_busy));

    // Active-instance view
    logic        m_req, m_we, r_valid, r_err, r_mis;
    logic [31:0] m_addr, m_wdata, r_rdata;
    logic [3:0]  m_wmask;
    assign m_req   = use_ns ? n_mem_req   : s_mem_req;
    assign m_we    = use_ns ? n_mem_we    : s_mem_we;
    assign m_addr  = use_ns ? n_mem_addr  : s_mem_addr;
    assign m_wdata = use_ns ? n_mem_wdata : s_mem_wdata;
    assign m_wmask = use_ns ? n_mem_wmask : s_mem_wmask;
    assign r_valid = use_ns ? n_rsp_valid : s_rsp_valid;
    assign r_err   = use_ns ? n_rsp_err   : s_rsp_err;
    assign r_mis   = use_ns ? n_rsp_mis   : s_rsp_mis;
    assign r_rdata = use_ns ? n_rsp_rdata : s_rsp_rdata;

    // Memory model
    logic [31:0] ov_addr0, ov_data0, ov_addr1, ov_data1, err_addr, hold_addr;
    logic        err_en, hold_en;
    int          wait_cycles = 0;
    int          wcnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == ov_addr0) return ov_data0;
        if (a == ov_addr1) return ov_data1;
        return (a * 32'h9E3779B1) ^ 32'hA5A5A5A5;
    endfunction

    always_comb begin
        mem_rdata  = mem_word(m_addr);
        mem_err    = err_en && (m_addr == err_addr);
        mem_rvalid = m_req && (wcnt >= wait_cycles) && !(hold_en && m_addr == hold_addr);
    end

    always @(posedge clk) wcnt <= (m_req && !mem_rvalid) ? wcnt + 1 : 0;

    int cyc = 0;
    int acc_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic [3:0] mask; logic we; logic [31:0] wdata; } beat_t;
    typedef struct { logic [31:0] rdata; logic err; logic mis; int lat; } rsp_t;
    beat_t beat_q[$];
    rsp_t  rsp_q[$];
    beat_t mon_b;
    rsp_t  mon_r;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Monitor: beats and responses compared against the scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (m_req && mem_rvalid) begin
                check("beat_pending", beat_q.size() != 0, 1);
                if (beat_q.size() != 0) begin
                    mon_b = beat_q.pop_front();
                    check("beat_addr", m_addr, mon_b.addr);
                    check("beat_mask", m_wmask, mon_b.mask);
                    check("beat_we", m_we, mon_b.we);
                    if (mon_b.we) check("beat_wdata", m_wdata & lanes(mon_b.mask), mon_b.wdata);
                end
            end
            if (r_valid) begin
                check("rsp_pending", rsp_q.size() != 0, 1);
                if (rsp_q.size() != 0) begin
                    mon_r = rsp_q.pop_front();
                    check("rsp_rdata", r_rdata, mon_r.rdata);
                    check("rsp_err", r_err, mon_r.err);
                    check("rsp_mis", r_mis, mon_r.mis);
                    check("rsp_latency", cyc - acc_cyc, mon_r.lat);
                end
            end
        end
    end

    // Byte-wise reference: expected beats pushed, expected response returned
    task automatic build(input bit split, input logic we, input logic sign, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata, output rsp_t r);
        int size, lane, which, nb, issued;
        logic [31:0] w0, ba, w, word, rd;
        logic [3:0]  m [2];
        logic [31:0] wd [2];
        beat_t b;
        size = 1 << len;
        r.rdata = '0; r.err = 1'b0; r.mis = 1'b0; r.lat = 1;
        if (len == 2'd3) begin r.err = 1'b1; return; end
        if ((addr % size) != 0 && !split) begin r.mis = 1'b1; return; end
        w0 = addr & ~32'h3;
        m[0] = '0; m[1] = '0; wd[0] = '0; wd[1] = '0; rd = '0;
        for (int i = 0; i < size; i++) begin
            ba = addr + i;
            w = ba & ~32'h3;
            lane = int'(ba[1:0]);
            which = (w == w0) ? 0 : 1;
            m[which][lane] = 1'b1;
            wd[which][8*lane +: 8] = wdata[8*i +: 8];
            word = mem_word(w);
            rd[8*i +: 8] = word[8*lane +: 8];
        end
        nb = (m[1] != 4'd0) ? 2 : 1;
        issued = nb;
        if (err_en && w0 == err_addr) begin issued = 1; r.err = 1'b1; end
        else if (nb == 2 && err_en && (w0 + 32'd4) == err_addr) r.err = 1'b1;
        for (int k = 0; k < issued; k++) begin
            b.addr = w0 + 32'(4*k); b.mask = m[k]; b.we = we; b.wdata = wd[k];
            beat_q.push_back(b);
        end
        if (!we && !r.err) begin
            if (sign && rd[8*size-1])
                for (int j = 8*size; j < 32; j++) rd[j] = 1'b1;
            r.rdata = rd;
        end
        r.lat = 1 + issued * (wait_cycles + 1);
    endtask

    task automatic drive(input bit split, input logic we, input logic sign, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold_cyc);
        @(posedge clk); #1;
        use_ns = !split;
        req_we = we; req_sign = sign; req_len = len; req_addr = addr; req_wdata = wdata;
        if (split) s_req_valid = 1'b1; else n_req_valid = 1'b1;
        acc_cyc = cyc;
        repeat (1 + hold_cyc) @(posedge clk);
        #1;
        s_req_valid = 1'b0; n_req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_len = 2'($urandom_range(0, 3));
    endtask

    task automatic do_req(input bit split, input logic we, input logic sign, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold_cyc = 0);
        rsp_t r;
        build(split, we, sign, len, addr, wdata, r);
        rsp_q.push_back(r);
        drive(split, we, sign, len, addr, wdata, hold_cyc);
        for (int i = 0; i < 200 && rsp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("rsp_outstanding", rsp_q.size(), 0);
        check("beats_outstanding", beat_q.size(), 0);
        rsp_q.delete(); beat_q.delete();
    endtask

    initial begin
        rsp_t dummy;
        int   k;
        reset_n = 1'b0; use_ns = 1'b0; s_req_valid = 1'b0; n_req_valid = 1'b0;
        req_we = 1'b0; req_sign = 1'b0; req_len = 2'd0; req_addr = '0; req_wdata = '0;
        ov_addr0 = 32'h1; ov_addr1 = 32'h1; ov_data0 = '0; ov_data1 = '0;
        err_en = 1'b0; err_addr = '0; hold_en = 1'b0; hold_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", s_req_ready, 1);
        check("rst_busy", s_busy, 0);
        check("rst_mem_req", s_mem_req, 0);
        check("rst_mem_we", s_mem_we, 0);
        check("rst_mem_addr", s_mem_addr, 0);
        check("rst_mem_wmask", s_mem_wmask, 0);
        check("rst_mem_wdata", s_mem_wdata, 0);
        check("rst_rsp_valid", s_rsp_valid, 0);
        check("rst_rsp_err", s_rsp_err, 0);
        check("rst_rsp_rdata", s_rsp_rdata, 0);
        check("rst_ns_ready", n_req_ready, 1);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed vectors on the splitting instance
        ov_addr0 = 32'h100; ov_data0 = 32'hDEADBEEF;
        do_req(1, 0, 0, 2'd2, 32'h100, 32'h0);
        ov_data0 = 32'h80112233; ov_addr1 = 32'h104; ov_data1 = 32'h445566FF;
        do_req(1, 0, 1, 2'd1, 32'h103, 32'h0);
        do_req(1, 1, 0, 2'd2, 32'h102, 32'h11223344);
        do_req(1, 0, 0, 2'd0, 32'h1F7, 32'h0);
        do_req(1, 0, 1, 2'd0, 32'h1F6, 32'h0);
        do_req(1, 0, 0, 2'd1, 32'h1F4, 32'h0);
        do_req(1, 0, 1, 2'd2, 32'h101, 32'h0);
        do_req(1, 1, 0, 2'd1, 32'h107, 32'hCAFEBABE);
        do_req(1, 1, 0, 2'd0, 32'h205, 32'h000000AB);
        do_req(1, 0, 0, 2'd3, 32'h200, 32'h0);
        wait_cycles = 2;
        do_req(1, 0, 1, 2'd2, 32'h2FE, 32'h0);
        wait_cycles = 3;
        do_req(1, 0, 0, 2'd2, 32'h300, 32'h0, 2);
        wait_cycles = 0;
        err_en = 1'b1; err_addr = 32'hFFFFFFFC;
        do_req(1, 0, 0, 2'd2, 32'hFFFFFFFE, 32'h0);
        err_en = 1'b0;
        do_req(1, 0, 0, 2'd2, 32'hFFFFFFFE, 32'h0);
        err_en = 1'b1; err_addr = 32'h404;
        do_req(1, 0, 0, 2'd2, 32'h403, 32'h0);
        err_en = 1'b0;

        // Non-splitting instance
        do_req(0, 0, 0, 2'd2, 32'h101, 32'h0);
        do_req(0, 0, 0, 2'd2, 32'h100, 32'h0);
        do_req(0, 0, 1, 2'd1, 32'h103, 32'h0);
        do_req(0, 1, 0, 2'd0, 32'h107, 32'h5A);
        do_req(0, 0, 1, 2'd1, 32'h102, 32'h0);
        do_req(0, 0, 0, 2'd3, 32'h108, 32'h0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            wait_cycles = $urandom_range(0, 2);
            k = $urandom_range(0, 9);
            do_req(1, 1'($urandom), 1'($urandom), (k == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   $urandom, $urandom);
        end
        for (int i = 0; i < 20; i++) begin
            wait_cycles = $urandom_range(0, 1);
            do_req(0, 1'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), $urandom, $urandom);
        end
        wait_cycles = 0;

        // Reset while beat 1 is waiting for its completion
        hold_en = 1'b1; hold_addr = 32'h504;
        build(1, 0, 0, 2'd2, 32'h502, 32'h0, dummy);
        drive(1, 0, 0, 2'd2, 32'h502, 32'h0, 0);
        for (int i = 0; i < 50 && !(s_mem_req && s_mem_addr == 32'h504); i++) @(negedge clk);
        check("beat1_reached", s_mem_req && s_mem_addr == 32'h504, 1);
        check("beat0_done", beat_q.size(), 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rstmid_mem_req", s_mem_req, 0);
        check("rstmid_busy", s_busy, 0);
        check("rstmid_ready", s_req_ready, 1);
        check("rstmid_mem_addr", s_mem_addr, 0);
        beat_q.delete();
        hold_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", s_rsp_valid, 0);
            check("post_rst_ready", s_req_ready, 1);
        end
        do_req(1, 0, 0, 2'd2, 32'h100, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/split_load_store_unit.md
SPLIT_LOAD_STORE_UNIT -- requirements
Module: split_load_store_unit

Interface
REQ-001: Parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002: Parameter SPLIT_EN, default 1; 1 = split misaligned accesses into two bus beats, 0 = report them as misaligned without bus traffic.
REQ-003: clk  input  1  sole clock, rising edge.
REQ-004: reset_n  input  1  asynchronous, active-low reset.
REQ-005: req_valid  input  1  core access request.
REQ-006: req_ready  output  1  unit can accept a request.
REQ-007: req_we, req_sign  input  1 each  store select; sign-extend load result.
REQ-008: req_len  input  2  size code: 0 byte, 1 half, 2 word, 3 dword (dword legal only when XLEN=64).
REQ-009: req_addr, req_wdata  input  XLEN each  byte address; store data, right-justified.
REQ-010: rsp_valid  output  1  one-cycle completion pulse.
REQ-011: rsp_rdata  output  XLEN  extended load data (0 for stores).
REQ-012: rsp_err, rsp_misaligned  output  1 each  bus/size error; unsplit misaligned access.
REQ-013: mem_req, mem_we  output  1 each  bus beat request; write beat.
REQ-014: mem_addr, mem_wdata  output  XLEN each  XLEN/8-aligned beat address; lane-positioned write data.
REQ-015: mem_wmask  output  XLEN/8  byte-lane enables (also valid for reads).
REQ-016: mem_rvalid, mem_err  input  1 each  beat completion; beat error (sampled with mem_rvalid).
REQ-017: mem_rdata  input  XLEN  read data for the completing beat.
REQ-018: busy  output  1  high in any state other than IDLE.

Function
REQ-019: FSM states IDLE, BEAT0, BEAT1, DONE; req_ready = (state==IDLE).
REQ-020: In IDLE, req_valid captures addr, wdata, len, sign, we into registers; transitions to BEAT0 next cycle, or DONE if misaligned with SPLIT_EN=0 or illegal len.
REQ-021: size = 1<<req_len bytes; off = addr mod XLEN/8; crossing = off+size > XLEN/8; misaligned = addr mod size != 0.
REQ-022: mem_req high throughout BEAT0/BEAT1; a beat completes in the cycle mem_req & mem_rvalid; mem_addr, mem_we, mem_wdata, mem_wmask stable until completion.
REQ-023: BEAT0: mem_addr = addr with low log2(XLEN/8) bits cleared; mem_wmask = ((1<<size)-1)<<off truncated to XLEN/8 bits; mem_wdata = wdata << 8*off.
REQ-024: BEAT1 (only if crossing and SPLIT_EN=1): mem_addr = BEAT0 address + XLEN/8 modulo 2^XLEN (wraps to 0); mem_wmask = remaining low lanes; mem_wdata = wdata >> 8*(XLEN/8-off).
REQ-025: BEAT0 completion -> BEAT1 if crossing and no mem_err, else DONE; BEAT1 completion -> DONE.
REQ-026: Load data assembly: BEAT0 lanes shifted down by off form low bytes; BEAT1 lanes fill the upper size-(XLEN/8-off) bytes; result masked to size then sign- or zero-extended per req_sign.
REQ-027: DONE: rsp_valid=1 for exactly one cycle, then IDLE; rsp_rdata/rsp_err/rsp_misaligned valid only while rsp_valid.
REQ-028: mem_err on BEAT0 aborts BEAT1 (no second mem_req); rsp_err=1, rsp_rdata=0.
REQ-029: Misaligned with SPLIT_EN=0: no mem_req, rsp_misaligned=1, rsp_err=0; naturally aligned accesses never set rsp_misaligned.
REQ-030: req_len=3 with XLEN=32: no mem_req, rsp_err=1.
REQ-031: Latency from acceptance cycle N with zero-wait memory: rsp_valid at N+2 (one beat), N+3 (split), N+1 (no bus traffic); each mem wait cycle adds one.
REQ-032: Requests presented while req_ready=0 are ignored; no queuing.

Reset
REQ-033: reset_n low asynchronously forces IDLE; mem_req, mem_we, rsp_valid, rsp_err, rsp_misaligned, busy = 0; mem_addr, mem_wdata, mem_wmask, rsp_rdata = 0; req_ready = 1 while reset_n low.
REQ-034: Reset mid-transaction drops mem_req immediately and discards the access; no rsp_valid is produced for it.

Verification
REQ-035: LW 0x100, mem_rdata 0xDEADBEEF zero-wait -> one beat addr 0x100 mask 0xF; rsp_rdata 0xDEADBEEF at N+2.
REQ-036: LH signed 0x103, SPLIT_EN=1, beat0 byte3=0x80, beat1 byte0=0xFF -> beats 0x100/mask 0x8, 0x104/mask 0x1; rsp_rdata 0xFFFFFF80 at N+3.
REQ-037: SW 0x102 data 0x11223344 -> beat0 0x100 mask 0xC wdata 0x33440000; beat1 0x104 mask 0x3 wdata 0x00001122.
REQ-038: SPLIT_EN=0, LW 0x101 -> no mem_req; rsp_valid at N+1 with rsp_misaligned=1.
REQ-039: LW 0xFFFFFFFE split, mem_err on beat0 -> no beat1, rsp_err=1; repeat without error -> beat1 addr 0x00000000.
REQ-040: reset_n low during BEAT1 with mem_rvalid withheld -> mem_req=0 same cycle, no rsp_valid, req_ready=1 after release.
